// File: rtl/symm_pkg.sv
// rtl/symm_pkg.sv - shared state type, derived counts and saturation helpers for symm_orth_seq
package symm_pkg;

  typedef enum logic [1:0] {IDLE, PH1, PH2, DONE} state_t;

  function automatic int ph1_len(input int n);
    return n * n * (n + 1) / 2;
  endfunction

  function automatic int ph2_len(input int n);
    return n * n * n;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

  localparam int N_DEF   = 4;
  localparam int DW_DEF  = 26;
  localparam int PH1_LEN = ph1_len(N_DEF);
  localparam int PH2_LEN = ph2_len(N_DEF);
  localparam int CNT_W   = cnt_w(N_DEF);
  localparam longint DW_MAX = (64'sd1 <<< (DW_DEF - 1)) - 64'sd1;
  localparam longint DW_MIN = -(64'sd1 <<< (DW_DEF - 1));

  // Values arrive sign-extended to 64 bits, so any accumulator up to 64 bits fits.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (x > hi) || (x < lo);
  endfunction

endpackage

// File: rtl/symm_mac.sv
// rtl/symm_mac.sv - shared signed multiply, floor-shift and accumulate unit
module symm_mac #(
  parameter int DW   = 26,
  parameter int FRAC = 13,
  parameter int ACCW = 2 * DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic                   i_first,
  input  logic signed [DW-1:0]   i_a,
  input  logic signed [DW-1:0]   i_b,
  output logic signed [ACCW-1:0] o_sum
);

  logic signed [2*DW-1:0] w_prod;
  logic signed [2*DW-1:0] w_shift;
  logic signed [ACCW-1:0] w_term;
  logic signed [ACCW-1:0] w_base;
  logic signed [ACCW-1:0] r_acc;

  assign w_prod  = i_a * i_b;
  assign w_shift = w_prod >>> FRAC;
  assign w_term  = ACCW'(w_shift);
  assign w_base  = i_first ? {ACCW{1'b0}} : r_acc;
  // Sum includes the current term so the last element value is usable in the same cycle.
  assign o_sum   = w_base + w_term;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/symm_orth_seq.sv
// rtl/symm_orth_seq.sv - sequential symmetric decorrelation engine (0.5*W*W'*W or 1.5W - 0.5*W*W'*W)
module symm_orth_seq
  import symm_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 26,
  parameter int FRAC = 13,
  parameter int ACCW = 2 * DW
) (
  input  logic              clk_orth,
  input  logic              rst_orth,
  input  logic              start,
  input  logic              mode,
  input  logic [N*N*DW-1:0] w_in,
  output logic [N*N*DW-1:0] w_out,
  output logic              busy,
  output logic              done,
  output logic              sat
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_i;
  logic [CW-1:0] r_j;
  logic [CW-1:0] r_k;
  logic          r_mode;
  logic          r_sat;

  logic signed [DW-1:0] r_w [N][N];
  logic signed [DW-1:0] r_g [N][N];
  logic signed [DW-1:0] r_h [N][N];

  logic                   w_k_last;
  logic                   w_j_last;
  logic                   w_i_last;
  logic                   w_run_end;
  logic signed [DW-1:0]   w_a;
  logic signed [DW-1:0]   w_b;
  logic signed [ACCW-1:0] w_sum;
  logic signed [63:0]     w_sum64;
  logic signed [DW-1:0]   w_g_val;
  logic                   w_g_hit;
  logic signed [ACCW-1:0] w_wext;
  logic signed [ACCW-1:0] w_post;
  logic signed [63:0]     w_post64;
  logic signed [DW-1:0]   w_res;
  logic                   w_h_hit;

  assign w_k_last  = (r_k == LAST);
  assign w_j_last  = (r_j == LAST);
  assign w_i_last  = (r_i == LAST);
  assign w_run_end = (r_state == PH2) && w_k_last && w_j_last && w_i_last;

  assign busy = (r_state == PH1) || (r_state == PH2);
  assign done = (r_state == DONE);

  always_ff @(posedge clk_orth) begin
    if (rst_orth) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = PH1;
      PH1:  if (w_k_last && w_j_last && w_i_last) w_next = PH2;
      PH2:  if (w_k_last && w_j_last && w_i_last) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // PH1 walks the upper triangle (j starts at i); PH2 walks the full matrix.
  always_ff @(posedge clk_orth) begin
    if (rst_orth) begin
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_mode <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_i    <= '0;
            r_j    <= '0;
            r_k    <= '0;
            r_mode <= mode;
            r_sat  <= 1'b0;
          end
        end
        PH1: begin
          if (w_k_last) begin
            r_k <= '0;
            if (w_g_hit) r_sat <= 1'b1;
            if (w_j_last) begin
              if (w_i_last) begin
                r_i <= '0;
                r_j <= '0;
              end else begin
                r_i <= r_i + 1'b1;
                r_j <= r_i + 1'b1;
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        PH2: begin
          if (w_k_last) begin
            r_k <= '0;
            if (w_h_hit) r_sat <= 1'b1;
            if (w_j_last) begin
              r_j <= '0;
              r_i <= w_i_last ? '0 : r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_a = r_w[r_i][r_k];
    w_b = r_w[r_j][r_k];
    if (r_state == PH2) begin
      w_a = r_g[r_i][r_k];
      w_b = r_w[r_k][r_j];
    end
  end

  symm_mac #(
    .DW   (DW),
    .FRAC (FRAC),
    .ACCW (ACCW)
  ) u_mac (
    .clk     (clk_orth),
    .rst     (rst_orth),
    .i_en    (busy),
    .i_first (r_k == '0),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_sum   (w_sum)
  );

  always_comb begin
    w_sum64  = 64'(w_sum);
    w_g_val  = DW'(sat_w(w_sum64, DW));
    w_g_hit  = sat_hit(w_sum64, DW);
    w_wext   = ACCW'(r_w[r_i][r_j]);
    w_post   = r_mode ? (w_wext + (w_wext >>> 1)) - (w_sum >>> 1) : (w_sum >>> 1);
    w_post64 = 64'(w_post);
    w_res    = DW'(sat_w(w_post64, DW));
    w_h_hit  = sat_hit(w_post64, DW);
  end

  always_ff @(posedge clk_orth) begin
    if (r_state == IDLE && start) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_w[r][c] <= w_in[(r*N+c)*DW +: DW];
        end
      end
    end
    if (r_state == PH1 && w_k_last) begin
      r_g[r_i][r_j] <= w_g_val;
      r_g[r_j][r_i] <= w_g_val;
    end
    if (r_state == PH2 && w_k_last) begin
      r_h[r_i][r_j] <= w_res;
    end
  end

  // The final element is still in flight on the last PH2 cycle, so it bypasses the buffer.
  always_ff @(posedge clk_orth) begin
    if (rst_orth) begin
      w_out <= '0;
      sat   <= 1'b0;
    end else if (w_run_end) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          if (r == N - 1 && c == N - 1) begin
            w_out[(r*N+c)*DW +: DW] <= w_res;
          end else begin
            w_out[(r*N+c)*DW +: DW] <= r_h[r][c];
          end
        end
      end
      sat <= r_sat | w_h_hit;
    end
  end

endmodule
